// File: rtl/key_pkg.sv
// Shared constants for the key-driven mode controller: key codes, the RUN mode
// value and the decoded command type.
package key_pkg;

    localparam int unsigned KEY_MODE    = 1;
    localparam int unsigned KEY_NEXT    = 2;
    localparam int unsigned KEY_INC     = 3;
    localparam int unsigned KEY_DEC     = 4;
    localparam int unsigned KEY_CONFIRM = 5;
    localparam int unsigned KEY_CANCEL  = 6;

    localparam int unsigned RUN_MODE = 0;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_MODE,
        CMD_NEXT,
        CMD_INC,
        CMD_DEC,
        CMD_CONFIRM,
        CMD_CANCEL
    } key_cmd_e;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for the key-valid level. After reset it stays disarmed
// until the level has been seen low, so a key held through reset is not an event.
module key_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;
    logic armed_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= level_i;
            armed_q <= armed_q | ~level_i;
        end
    end

    assign rise_o = level_i & ~prev_q & armed_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Key-driven mode/field controller with registered single-cycle strobes.
// Optional edit-idle timeout enabled by defining KEY_MODE_TIMEOUT_EN.
module key_mode_ctrl
    import key_pkg::*;
#(
    parameter int CODE_W      = 4,
    parameter int N_MODES     = 3,
    parameter int N_FIELDS    = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        key_vaild,
    input  logic [CODE_W-1:0]                           key_code,
    output logic [$clog2(N_MODES)-1:0]                  mode,
    output logic [((N_FIELDS > 1) ? $clog2(N_FIELDS) : 1)-1:0] field,
    output logic                                        inc_pulse,
    output logic                                        dec_pulse,
    output logic                                        commit_pulse,
    output logic                                        cancel_pulse,
    output logic                                        timeout_pulse
);

    localparam int MODE_W  = $clog2(N_MODES);
    localparam int FIELD_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;

    localparam logic [MODE_W-1:0]  RUN_M      = MODE_W'(RUN_MODE);
    localparam logic [MODE_W-1:0]  MODE_LAST  = MODE_W'(N_MODES - 1);
    localparam logic [FIELD_W-1:0] FIELD_LAST = FIELD_W'(N_FIELDS - 1);

    generate
        if (N_MODES < 2 || N_MODES > 16) begin : g_bad_modes
            $error("key_mode_ctrl: N_MODES must be 2..16");
        end
        if (N_FIELDS < 1 || N_FIELDS > 16) begin : g_bad_fields
            $error("key_mode_ctrl: N_FIELDS must be 1..16");
        end
        if (TIMEOUT_CYC < 2) begin : g_bad_timeout
            $error("key_mode_ctrl: TIMEOUT_CYC must be >= 2");
        end
    endgenerate

    logic     key_evt;
    key_cmd_e cmd;
    logic     in_edit;

    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [FIELD_W-1:0] field_q, field_d;
    logic inc_q, inc_d, dec_q, dec_d;
    logic commit_q, commit_d, cancel_q, cancel_d;

    key_edge_detect u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .level_i (key_vaild),
        .rise_o  (key_evt)
    );

    // Only the event cycle's code matters; a held key decodes to nothing.
    always_comb begin
        cmd = CMD_NONE;
        if (key_evt) begin
            case (key_code)
                CODE_W'(KEY_MODE):    cmd = CMD_MODE;
                CODE_W'(KEY_NEXT):    cmd = CMD_NEXT;
                CODE_W'(KEY_INC):     cmd = CMD_INC;
                CODE_W'(KEY_DEC):     cmd = CMD_DEC;
                CODE_W'(KEY_CONFIRM): cmd = CMD_CONFIRM;
                CODE_W'(KEY_CANCEL):  cmd = CMD_CANCEL;
                default:              cmd = CMD_NONE;
            endcase
        end
    end

    assign in_edit = (mode_q != RUN_M);

`ifdef KEY_MODE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    always_comb begin
        mode_d   = mode_q;
        field_d  = field_q;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        commit_d = 1'b0;
        cancel_d = 1'b0;
        case (cmd)
            CMD_MODE: begin
                field_d = '0;
                mode_d  = (mode_q == MODE_LAST) ? RUN_M : mode_q + MODE_W'(1);
            end
            CMD_NEXT: begin
                if (in_edit) begin
                    field_d = (field_q == FIELD_LAST) ? '0 : field_q + FIELD_W'(1);
                end
            end
            CMD_INC:  inc_d = in_edit;
            CMD_DEC:  dec_d = in_edit;
            CMD_CONFIRM: begin
                if (in_edit) begin
                    commit_d = 1'b1;
                    mode_d   = RUN_M;
                    field_d  = '0;
                end
            end
            CMD_CANCEL: begin
                if (in_edit) begin
                    cancel_d = 1'b1;
                    mode_d   = RUN_M;
                    field_d  = '0;
                end
            end
            default: ;
        endcase
`ifdef KEY_MODE_TIMEOUT_EN
        // Any key event beats expiry; staying in (or entering) an edit mode reloads.
        tmo_d = 1'b0;
        cnt_d = cnt_q;
        if (key_evt) begin
            cnt_d = (mode_d != RUN_M) ? CNT_RELOAD : '0;
        end else if (!in_edit) begin
            cnt_d = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
            tmo_d   = 1'b1;
            mode_d  = RUN_M;
            field_d = '0;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q   <= RUN_M;
            field_q  <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            commit_q <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            field_q  <= field_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            commit_q <= commit_d;
            cancel_q <= cancel_d;
        end
    end

`ifdef KEY_MODE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_pulse = tmo_q;
`else
    assign timeout_pulse = 1'b0;
`endif

    assign mode         = mode_q;
    assign field        = field_q;
    assign inc_pulse    = inc_q;
    assign dec_pulse    = dec_q;
    assign commit_pulse = commit_q;
    assign cancel_pulse = cancel_q;

endmodule
